// File: rtl/gray_sync_decoder.sv
// Brings a Gray-coded count from a foreign clock domain into clk, decodes it to
// binary and classifies each accepted advance as hold, single step or illegal skip.
module gray_sync_decoder #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] gray_in,
    input  logic         err_clr,
    output logic [N-1:0] bin_out,
    output logic         bin_valid,
    output logic         step,
    output logic         skip_err,
    output logic [7:0]   skip_cnt
);

    localparam int FW = $clog2(SYNC_STAGES);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t         state_q, state_d;
    logic [FW-1:0]  fill_cnt_q, fill_cnt_d;
    logic [N-1:0]   sync_q [SYNC_STAGES];
    logic [N-1:0]   sync_d [SYNC_STAGES];
    logic [N-1:0]   bin_out_q, bin_out_d;
    logic           bin_valid_q, bin_valid_d;
    logic           step_q, step_d;
    logic           skip_err_q, skip_err_d;
    logic [7:0]     skip_cnt_q, skip_cnt_d;

    logic [N-1:0]   gray_sync;
    logic [N-1:0]   bin_dec;
    logic [N-1:0]   delta;
    logic           skip_det;

    // Synchronizer chain runs every cycle regardless of enable.
    always_comb begin
        sync_d[0] = gray_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign gray_sync = sync_q[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at and above its position.
    always_comb begin
        bin_dec = '0;
        for (int unsigned i = 0; i < N; i++) begin
            bin_dec[i] = ^(gray_sync >> i);
        end
    end

    assign delta = bin_dec - bin_out_q;

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        bin_out_d   = bin_out_q;
        bin_valid_d = bin_valid_q;
        step_d      = 1'b0;
        skip_det    = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (fill_cnt_q == FW'(SYNC_STAGES - 1)) begin
                    state_d = ST_PRIME;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            ST_PRIME: begin
                if (enable) begin
                    bin_out_d   = bin_dec;
                    bin_valid_d = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                // Dropping enable forces a fresh baseline on re-enable.
                if (!enable) begin
                    state_d = ST_PRIME;
                end else if (delta != '0) begin
                    bin_out_d = bin_dec;
                    if (delta == N'(1)) begin
                        step_d = 1'b1;
                    end else begin
                        skip_det = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // A skip in the same cycle as err_clr wins and restarts the count at 1.
    always_comb begin
        skip_err_d = skip_err_q;
        skip_cnt_d = skip_cnt_q;
        if (state_q != ST_FILL && err_clr) begin
            skip_err_d = 1'b0;
            skip_cnt_d = '0;
        end
        if (skip_det) begin
            skip_err_d = 1'b1;
            if (skip_cnt_d != '1) begin
                skip_cnt_d = skip_cnt_d + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            state_q     <= ST_FILL;
            fill_cnt_q  <= '0;
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            step_q      <= 1'b0;
            skip_err_q  <= 1'b0;
            skip_cnt_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            bin_out_q   <= bin_out_d;
            bin_valid_q <= bin_valid_d;
            step_q      <= step_d;
            skip_err_q  <= skip_err_d;
            skip_cnt_q  <= skip_cnt_d;
        end
    end

    assign bin_out   = bin_out_q;
    assign bin_valid = bin_valid_q;
    assign step      = step_q;
    assign skip_err  = skip_err_q;
    assign skip_cnt  = skip_cnt_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Scoreboard bench for gray_sync_decoder: a cycle model pushes expected outputs
// at each rising edge; they are popped and compared on the following falling edge.
module tb_gray_sync_decoder;

    localparam int N  = 4;
    localparam int SS = 2;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic         enable  = 1'b1;
    logic         err_clr = 1'b0;
    logic [N-1:0] gray_in = '0;
    logic [N-1:0] bin_out;
    logic         bin_valid;
    logic         step;
    logic         skip_err;
    logic [7:0]   skip_cnt;
    logic [14:0]  obs;

    gray_sync_decoder #(
        .N          (N),
        .SYNC_STAGES(SS)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .gray_in  (gray_in),
        .err_clr  (err_clr),
        .bin_out  (bin_out),
        .bin_valid(bin_valid),
        .step     (step),
        .skip_err (skip_err),
        .skip_cnt (skip_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {bin_out, bin_valid, step, skip_err, skip_cnt};

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    logic [14:0]  exp_q[$];

    logic [N-1:0] m_hist[$];
    int           m_mode;
    int           m_fill;
    logic [N-1:0] m_bout;
    logic         m_valid;
    logic         m_step;
    logic         m_err;
    logic [7:0]   m_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] b2g(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
        logic [N-1:0] b;
        b = g;
        for (int i = 1; i < N; i++) b = b ^ (g >> i);
        return b;
    endfunction

    function automatic logic [14:0] model_pack();
        return {m_bout, m_valid, m_step, m_err, m_cnt};
    endfunction

    task automatic model_reset();
        m_hist = {};
        for (int i = 0; i < SS; i++) m_hist.push_back('0);
        m_mode  = 0;
        m_fill  = 0;
        m_bout  = '0;
        m_valid = 1'b0;
        m_step  = 1'b0;
        m_err   = 1'b0;
        m_cnt   = '0;
    endtask

    // Mode 0 = filling, 1 = waiting for a baseline, 2 = tracking.
    task automatic model_edge();
        logic [N-1:0] b;
        logic [N-1:0] d;
        logic         skip;
        int           old_mode;
        if (!reset) begin
            model_reset();
        end else begin
            b        = g2b(m_hist[SS-1]);
            old_mode = m_mode;
            skip     = 1'b0;
            m_step   = 1'b0;
            case (m_mode)
                0: if (m_fill == SS - 1) m_mode = 1; else m_fill++;
                1: if (enable) begin
                       m_bout  = b;
                       m_valid = 1'b1;
                       m_mode  = 2;
                   end
                default: if (!enable) begin
                       m_mode = 1;
                   end else begin
                       d = b - m_bout;
                       if (d == 1) m_step = 1'b1;
                       else if (d >= 2) skip = 1'b1;
                       m_bout = b;
                   end
            endcase
            if (old_mode != 0 && err_clr) begin
                m_err = 1'b0;
                m_cnt = '0;
            end
            if (skip) begin
                m_err = 1'b1;
                if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
            end
            m_hist.push_front(gray_in);
            void'(m_hist.pop_back());
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            exp_q.push_back(model_pack());
            @(negedge clk);
            check_val("outs", 32'(obs), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic put(input int v);
        gray_in = b2g(N'(v));
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(model_pack());
        check_val("reset_now", 32'(obs), 32'(exp_q.pop_front()));
    endtask

    initial begin
        model_reset();
        #2;
        apply_reset();
        @(negedge clk);
        reset = 1'b1;

        // Bring-up with gray 0: valid appears after the third edge.
        cyc(2);
        check_val("r30_valid_early", 32'(bin_valid), 32'd0);
        cyc(1);
        check_val("r30_valid", 32'(bin_valid), 32'd1);
        check_val("r30_bin", 32'(bin_out), 32'd0);
        check_val("r30_step", 32'(step), 32'd0);
        cyc(1);

        // Single steps with three-edge latency and one pulse each.
        for (int v = 1; v <= 3; v++) begin
            put(v);
            cyc(2);
            check_val("r31_step_early", 32'(step), 32'd0);
            check_val("r31_bin_early", 32'(bin_out), 32'(v - 1));
            cyc(1);
            check_val("r31_step", 32'(step), 32'd1);
            check_val("r31_bin", 32'(bin_out), 32'(v));
            cyc(1);
            check_val("r31_step_once", 32'(step), 32'd0);
        end

        // Count up to 15 then wrap to 0.
        for (int v = 4; v <= 15; v++) begin
            put(v);
            cyc(4);
        end
        put(0);
        cyc(3);
        check_val("r32_bin", 32'(bin_out), 32'd0);
        check_val("r32_step", 32'(step), 32'd1);
        check_val("r32_err", 32'(skip_err), 32'd0);
        cyc(1);

        // Skip from 1 to 3, then clear.
        put(1);
        cyc(4);
        gray_in = 4'b0010;
        cyc(3);
        check_val("r33_bin", 32'(bin_out), 32'd3);
        check_val("r33_step", 32'(step), 32'd0);
        check_val("r33_err", 32'(skip_err), 32'd1);
        check_val("r33_cnt", 32'(skip_cnt), 32'd1);
        pulse_clr();
        check_val("r33_clr_err", 32'(skip_err), 32'd0);
        check_val("r33_clr_cnt", 32'(skip_cnt), 32'd0);

        // err_clr coinciding with a detected skip leaves err set and count at 1.
        put(9);
        cyc(4);
        put(14);
        cyc(4);
        check_val("setwin_pre_cnt", 32'(skip_cnt), 32'd2);
        put(3);
        cyc(2);
        pulse_clr();
        check_val("setwin_err", 32'(skip_err), 32'd1);
        check_val("setwin_cnt", 32'(skip_cnt), 32'd1);
        pulse_clr();

        // Disabled while the count moves 2 -> 9, re-enable re-baselines.
        put(2);
        cyc(4);
        pulse_clr();
        enable = 1'b0;
        for (int v = 3; v <= 9; v++) begin
            put(v);
            cyc(1);
        end
        cyc(3);
        check_val("r34_hold", 32'(bin_out), 32'd2);
        enable = 1'b1;
        cyc(1);
        check_val("r34_bin", 32'(bin_out), 32'd9);
        check_val("r34_step", 32'(step), 32'd0);
        check_val("r34_err", 32'(skip_err), 32'd0);

        // Skip every cycle to drive the counter into saturation.
        for (int i = 0; i < 262; i++) begin
            put((i % 2 == 0) ? 0 : 8);
            cyc(1);
        end
        check_val("sat_cnt", 32'(skip_cnt), 32'd255);
        check_val("sat_err", 32'(skip_err), 32'd1);
        put(0);
        cyc(3);
        pulse_clr();
        check_val("sat_clr", 32'(skip_cnt), 32'd0);

        // Reset mid-count at 7.
        for (int v = 1; v <= 7; v++) begin
            put(v);
            cyc(4);
        end
        check_val("r35_pre", 32'(bin_out), 32'd7);
        apply_reset();
        check_val("r35_bin_zero", 32'(bin_out), 32'd0);
        check_val("r35_valid_zero", 32'(bin_valid), 32'd0);
        cyc(1);
        reset = 1'b1;
        cyc(2);
        check_val("r35_valid_early", 32'(bin_valid), 32'd0);
        cyc(1);
        check_val("r35_bin", 32'(bin_out), 32'd7);
        check_val("r35_valid", 32'(bin_valid), 32'd1);
        check_val("r35_step", 32'(step), 32'd0);
        check_val("r35_err", 32'(skip_err), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            gray_in = N'($urandom);
            enable  = ($urandom_range(0, 7) != 0);
            err_clr = ($urandom_range(0, 15) == 0);
            cyc(1);
        end
        enable  = 1'b1;
        err_clr = 1'b0;
        cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gray_sync_decoder.md
GRAY_SYNC_DECODER -- requirements
Module: gray_sync_decoder

Interface
REQ-001 Parameter N, default 4, SHALL set the Gray/binary count width; legal range N >= 2.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth; legal range SYNC_STAGES >= 2.
REQ-003 clk  input  1  SHALL be the destination-domain clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 enable  input  1  SHALL gate decode-stage updates; the synchronizer chain is not gated.
REQ-006 gray_in  input  N  SHALL carry the Gray count from a foreign clock domain; the module treats it as asynchronous.
REQ-007 err_clr  input  1  SHALL be a synchronous clear of skip_err.
REQ-008 bin_out  output  N  SHALL carry the registered binary value of the last accepted sample.
REQ-009 bin_valid  output  1  SHALL be high once bin_out holds a decoded sample.
REQ-010 step  output  1  SHALL be a one-cycle pulse when the count advanced by exactly 1, modulo 2^N.
REQ-011 skip_err  output  1  SHALL be a sticky flag that sets on an illegal advance.
REQ-012 skip_cnt  output  8  SHALL count illegal advances and saturate at 255.

Function
REQ-013 gray_in SHALL pass through SYNC_STAGES flops (sync[0..SYNC_STAGES-1]) every cycle, independent of enable.
REQ-014 Decode SHALL compute bin[N-1] = g[N-1] and bin[i] = bin[i+1] XOR g[i] on the final sync stage output.
REQ-015 delta SHALL be computed as (bin - bin_out) mod 2^N, N bits wide, unsigned.
REQ-016 The FSM SHALL have three states: FILL, PRIME, RUN.
REQ-017 FILL SHALL count SYNC_STAGES cycles after reset release, then move to PRIME; outputs hold reset values while in FILL.
REQ-018 In PRIME with enable=1, the FSM SHALL load bin_out, set bin_valid=1, keep step=0, leave skip_err unchanged, and move to RUN.
REQ-019 In PRIME with enable=0, the FSM SHALL stay in PRIME.
REQ-020 In RUN with enable=1 and delta=0: bin_out holds, step=0.
REQ-021 In RUN with enable=1 and delta=1: bin_out loads bin, step=1 for that cycle.
REQ-022 In RUN with enable=1 and delta>=2: bin_out loads bin, step=0, skip_err sets, skip_cnt increments unless it is at 255.
REQ-023 In RUN with enable=0: bin_out holds, step=0, and the FSM moves to PRIME, so the first sample after re-enable is a new baseline with no error.
REQ-024 Wrap-around SHALL be legal: bin 2^N-1 to 0 gives delta=1, step=1, no error.
REQ-025 err_clr=1 SHALL clear skip_err and skip_cnt next edge; when a skip is detected in the same cycle, set wins: skip_err=1, skip_cnt=1.
REQ-026 Latency: a gray_in value stable before edge E1 SHALL appear on bin_out, with step, after edge E(SYNC_STAGES+1).
REQ-027 bin_valid SHALL stay high once set, until reset.

Reset
REQ-028 reset=0 SHALL immediately force all sync flops=0, bin_out=0, bin_valid=0, step=0, skip_err=0, skip_cnt=0, FSM=FILL, regardless of clk.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight samples; after release the FILL/PRIME sequence restarts.

Verification (N=4, SYNC_STAGES=2)
REQ-030 Release reset with gray_in=0000 and enable=1 -> bin_valid rises after the 3rd edge, bin_out=0, step never pulses.
REQ-031 gray_in steps 0000, 0001, 0011, 0010, one value per 4 cycles -> bin_out 0, 1, 2, 3, one step pulse per change, 3 edges after each change.
REQ-032 Drive count to gray 1000 (bin 15), then 0000 -> bin_out=0, step=1, skip_err=0.
REQ-033 In RUN at gray 0001, drive 0010 -> bin_out=3, step=0, skip_err=1, skip_cnt=1; assert err_clr for 1 cycle -> skip_err=0, skip_cnt=0.
REQ-034 enable=0 for 10 cycles while gray_in moves from bin 2 to bin 9, then enable=1 -> bin_out=9, step=0, skip_err=0.
REQ-035 Assert reset for 1 cycle mid-count at bin 7 -> outputs zero immediately; sequence restarts per REQ-030, with bin_out = current gray_in decoded and no step or error.
